dram_write_packer: RTL and testbench

Downstream stage of `gradient_compressor_top`: consumes its sparse `(dram_addr, dram_value)` update stream and packs it into fixed-width write bursts for the memory controller. Updates to an address already in the open burst are merged by saturating signed addition, so each address appears at most once per burst. A burst closes when full, on `flush`, or after an idle timeout, and is held stable on a valid/ready output port.

---
 rtl/dram_write_packer.sv | 205 ++++++++++++++++++++
 tb/tb_dram_write_packer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/dram_write_packer.sv
// ---------------------------------------------------------------------------
// dram_write_packer
//
// Packs a sparse (address, value) update stream into fixed-width write
// bursts for the memory controller. If an update hits an address that is
// already buffered in the open burst, it is merged into that slot with
// saturating signed addition, so each address appears at most once per
// burst. A burst closes when it is full, when flush is raised, or when no
// update has arrived for TIMEOUT cycles. A closed burst is held stable on a
// valid/ready output port until it is consumed.
//
// Ports
//   clock      : single clock, rising-edge
//   reset      : asynchronous, active-low reset
//   in_valid   : update valid
//   in_ready   : update accepted when in_valid && in_ready (FILL only)
//   in_addr    : update address
//   in_value   : signed update value
//   flush      : close the open partial burst
//   out_valid  : burst available
//   out_ready  : burst consumed when out_valid && out_ready
//   out_addr   : slot i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   out_value  : slot i at [i*VALUE_WIDTH +: VALUE_WIDTH]
//   out_count  : number of valid slots in the burst
//   idle       : FILL state with nothing buffered
// ---------------------------------------------------------------------------
module dram_write_packer #(
  parameter int ADDR_WIDTH  = 32,
  parameter int VALUE_WIDTH = 32,
  parameter int BURST_SIZE  = 4,
  parameter int TIMEOUT     = 16
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [ADDR_WIDTH-1:0]             in_addr,
  input  logic [VALUE_WIDTH-1:0]            in_value,
  input  logic                              flush,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [BURST_SIZE*ADDR_WIDTH-1:0]  out_addr,
  output logic [BURST_SIZE*VALUE_WIDTH-1:0] out_value,
  output logic [$clog2(BURST_SIZE+1)-1:0]   out_count,
  output logic                              idle
);

  localparam int CW = $clog2(BURST_SIZE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic {
    FILL = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          count_q, count_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [ADDR_WIDTH-1:0]  addr_q  [BURST_SIZE];
  logic [ADDR_WIDTH-1:0]  addr_d  [BURST_SIZE];
  logic [VALUE_WIDTH-1:0] value_q [BURST_SIZE];
  logic [VALUE_WIDTH-1:0] value_d [BURST_SIZE];

  // Holds in_ready low while reset is asserted and until the first clock
  // edge after release, even though the state register already reads FILL.
  logic alive_q, alive_d;

  logic                  accept;
  logic [BURST_SIZE-1:0] hit_vec;

  // Clamp the true sum into the signed VALUE_WIDTH range. The sum is formed
  // one bit wider; the top two bits disagreeing means it overflowed.
  function automatic logic [VALUE_WIDTH-1:0] sat_add(
    input logic [VALUE_WIDTH-1:0] a,
    input logic [VALUE_WIDTH-1:0] b
  );
    logic [VALUE_WIDTH:0] sum;
    sum = {a[VALUE_WIDTH-1], a} + {b[VALUE_WIDTH-1], b};
    if (sum[VALUE_WIDTH] != sum[VALUE_WIDTH-1]) begin
      if (sum[VALUE_WIDTH]) begin
        sat_add = {1'b1, {(VALUE_WIDTH-1){1'b0}}};
      end else begin
        sat_add = {1'b0, {(VALUE_WIDTH-1){1'b1}}};
      end
    end else begin
      sat_add = sum[VALUE_WIDTH-1:0];
    end
  endfunction

  assign in_ready  = alive_q && (state_q == FILL);
  assign out_valid = (state_q == SEND);
  assign out_count = (state_q == SEND) ? count_q : '0;
  assign idle      = (state_q == FILL) && (count_q == '0);
  assign accept    = in_valid && in_ready;
  assign alive_d   = 1'b1;

  // One-hot match of the incoming address against the occupied slots.
  // Addresses are unique within a burst, so at most one bit can be set.
  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < BURST_SIZE; i++) begin
      if ((CW'(i) < count_q) && (addr_q[i] == in_addr)) begin
        hit_vec[i] = 1'b1;
      end
    end
  end

  // Next-state logic: merge or append on accept, run the idle timer, and
  // decide whether the burst closes on this edge.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    timer_d = timer_q;
    addr_d  = addr_q;
    value_d = value_q;

    unique case (state_q)
      FILL: begin
        if (accept) begin
          if (|hit_vec) begin
            for (int i = 0; i < BURST_SIZE; i++) begin
              if (hit_vec[i]) begin
                value_d[i] = sat_add(value_q[i], in_value);
              end
            end
          end else begin
            for (int i = 0; i < BURST_SIZE; i++) begin
              if (CW'(i) == count_q) begin
                addr_d[i]  = in_addr;
                value_d[i] = in_value;
              end
            end
            count_d = count_q + CW'(1);
          end
        end

        if (accept || (count_d == '0)) begin
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end

        // Close conditions are judged on the post-accept contents.
        if ((count_d == CW'(BURST_SIZE)) ||
            (flush && (count_d != '0)) ||
            ((timer_d == TW'(TIMEOUT)) && (count_d != '0))) begin
          state_d = SEND;
        end
      end

      SEND: begin
        if (out_ready) begin
          state_d = FILL;
          count_d = '0;
          timer_d = '0;
          for (int i = 0; i < BURST_SIZE; i++) begin
            addr_d[i]  = '0;
            value_d[i] = '0;
          end
        end
      end

      default: begin
        state_d = FILL;
      end
    endcase
  end

  // Slots are cleared when a burst is consumed, so unused slots already
  // read as zero; outside SEND the ports are forced to zero as well.
  always_comb begin
    out_addr  = '0;
    out_value = '0;
    if (state_q == SEND) begin
      for (int i = 0; i < BURST_SIZE; i++) begin
        out_addr[i*ADDR_WIDTH +: ADDR_WIDTH]    = addr_q[i];
        out_value[i*VALUE_WIDTH +: VALUE_WIDTH] = value_q[i];
      end
    end
  end

  // State registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= FILL;
      count_q <= '0;
      timer_q <= '0;
      alive_q <= 1'b0;
      for (int i = 0; i < BURST_SIZE; i++) begin
        addr_q[i]  <= '0;
        value_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      timer_q <= timer_d;
      alive_q <= alive_d;
      for (int i = 0; i < BURST_SIZE; i++) begin
        addr_q[i]  <= addr_d[i];
        value_q[i] <= value_d[i];
      end
    end
  end

endmodule

// File: tb/tb_dram_write_packer.sv
// ---------------------------------------------------------------------------
// tb_dram_write_packer
//
// Directed bench for dram_write_packer with default parameters
// (32-bit address/value, 4-slot bursts, 16-cycle idle timeout).
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_dram_write_packer;

  logic         clock;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_addr;
  logic [31:0]  in_value;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_addr;
  logic [127:0] out_value;
  logic [2:0]   out_count;
  logic         idle;

  int tests_run;
  int tests_failed;

  dram_write_packer #(
    .ADDR_WIDTH (32),
    .VALUE_WIDTH(32),
    .BURST_SIZE (4),
    .TIMEOUT    (16)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_addr  (in_addr),
    .in_value (in_value),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_addr (out_addr),
    .out_value(out_value),
    .out_count(out_count),
    .idle     (idle)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance past the next rising edge and settle.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_stimulus(input logic v, input logic [31:0] a,
                                input logic [31:0] d, input logic f,
                                input logic r);
    in_valid  = v;
    in_addr   = a;
    in_value  = d;
    flush     = f;
    out_ready = r;
  endtask

  task automatic check_output(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] slot_addr(input int i);
    return out_addr[i*32 +: 32];
  endfunction

  function automatic logic [31:0] slot_value(input int i);
    return out_value[i*32 +: 32];
  endfunction

  initial begin
    int          wait_cycles;
    logic        stable;
    logic [127:0] held_addr;
    logic [127:0] held_value;

    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b0;
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // Reset values, before and after an edge while reset is held.
    #3;
    check_output("rst_in_ready", in_ready, 1'b0);
    check_output("rst_out_valid", out_valid, 1'b0);
    check_output("rst_idle", idle, 1'b1);
    check_output("rst_out_count", out_count, 3'd0);
    check_output("rst_out_addr", out_addr, 128'h0);
    tick();
    check_output("rst_in_ready_edge", in_ready, 1'b0);
    reset = 1'b1;
    #1;
    check_output("rel_in_ready_before_edge", in_ready, 1'b0);
    tick();
    check_output("rel_in_ready_after_edge", in_ready, 1'b1);

    // Full burst of four distinct addresses.
    apply_stimulus(1'b1, 32'h1000, 32'd10, 1'b0, 1'b1); tick();
    apply_stimulus(1'b1, 32'h1004, 32'd20, 1'b0, 1'b1); tick();
    apply_stimulus(1'b1, 32'h1008, 32'd30, 1'b0, 1'b1); tick();
    check_output("fill_no_valid_yet", out_valid, 1'b0);
    apply_stimulus(1'b1, 32'h100C, 32'd40, 1'b0, 1'b1); tick();
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    check_output("fill_out_valid", out_valid, 1'b1);
    check_output("fill_in_ready_low", in_ready, 1'b0);
    check_output("fill_count", out_count, 3'd4);
    check_output("fill_addr", out_addr, {32'h100C, 32'h1008, 32'h1004, 32'h1000});
    check_output("fill_value", out_value, {32'd40, 32'd30, 32'd20, 32'd10});
    tick();
    check_output("fill_released_valid", out_valid, 1'b0);
    check_output("fill_released_in_ready", in_ready, 1'b1);
    check_output("fill_released_idle", idle, 1'b1);

    // Merge into an existing slot, then flush.
    apply_stimulus(1'b1, 32'h2000, 32'd100, 1'b0, 1'b1); tick();
    apply_stimulus(1'b1, 32'h2000, -32'sd30, 1'b0, 1'b1); tick();
    check_output("merge_not_idle", idle, 1'b0);
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b1); tick();
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    check_output("merge_out_valid", out_valid, 1'b1);
    check_output("merge_count", out_count, 3'd1);
    check_output("merge_slot0_addr", slot_addr(0), 32'h2000);
    check_output("merge_slot0_value", slot_value(0), 32'd70);
    check_output("merge_slot1_zero", slot_value(1), 32'd0);
    tick();

    // Saturation in both directions within one burst.
    apply_stimulus(1'b1, 32'h3000, 32'h7FFFFFF0, 1'b0, 1'b1); tick();
    apply_stimulus(1'b1, 32'h3004, 32'h80000010, 1'b0, 1'b1); tick();
    apply_stimulus(1'b1, 32'h3000, 32'h00000100, 1'b0, 1'b1); tick();
    apply_stimulus(1'b1, 32'h3004, 32'hFFFFFF00, 1'b0, 1'b1); tick();
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b1); tick();
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    check_output("sat_count", out_count, 3'd2);
    check_output("sat_pos", slot_value(0), 32'h7FFFFFFF);
    check_output("sat_neg", slot_value(1), 32'h80000000);
    check_output("sat_addr1", slot_addr(1), 32'h3004);
    tick();

    // Idle timeout: last accept at edge N, out_valid after edge N+16.
    apply_stimulus(1'b1, 32'h4000, 32'd1, 1'b0, 1'b1); tick();
    apply_stimulus(1'b1, 32'h4004, 32'd2, 1'b0, 1'b1); tick();
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    wait_cycles = 0;
    while (!out_valid && wait_cycles < 40) begin
      tick();
      wait_cycles++;
    end
    check_output("timeout_latency", wait_cycles, 16);
    check_output("timeout_count", out_count, 3'd2);
    check_output("timeout_slot1", slot_addr(1), 32'h4004);
    tick();
    check_output("timeout_released", out_valid, 1'b0);

    // Flush on an empty buffer has no effect.
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b1); tick();
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    check_output("empty_flush_valid", out_valid, 1'b0);
    check_output("empty_flush_idle", idle, 1'b1);
    repeat (20) tick();
    check_output("empty_no_timeout", out_valid, 1'b0);

    // Backpressure: burst held for 10 cycles with a pending update waiting.
    apply_stimulus(1'b1, 32'h5000, 32'd1, 1'b0, 1'b0); tick();
    apply_stimulus(1'b1, 32'h5004, 32'd2, 1'b0, 1'b0); tick();
    apply_stimulus(1'b1, 32'h5008, 32'd3, 1'b0, 1'b0); tick();
    apply_stimulus(1'b1, 32'h500C, 32'd4, 1'b0, 1'b0); tick();
    apply_stimulus(1'b1, 32'h6000, 32'd99, 1'b1, 1'b0);
    held_addr  = {32'h500C, 32'h5008, 32'h5004, 32'h5000};
    held_value = {32'd4, 32'd3, 32'd2, 32'd1};
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (!(out_valid === 1'b1 && in_ready === 1'b0 &&
            out_addr === held_addr && out_value === held_value &&
            out_count === 3'd4)) begin
        stable = 1'b0;
      end
      tick();
    end
    check_output("bp_stable", stable, 1'b1);
    apply_stimulus(1'b1, 32'h6000, 32'd99, 1'b0, 1'b1); tick();
    check_output("bp_release_idle", idle, 1'b1);
    check_output("bp_release_in_ready", in_ready, 1'b1);
    tick();
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    check_output("bp_pending_taken", idle, 1'b0);
    tick();
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    check_output("bp_pending_count", out_count, 3'd1);
    check_output("bp_pending_slot", {slot_addr(0), slot_value(0)}, {32'h6000, 32'd99});
    tick();

    // Reset mid-fill discards buffered entries.
    apply_stimulus(1'b1, 32'h7100, 32'd5, 1'b0, 1'b1); tick();
    apply_stimulus(1'b1, 32'h7104, 32'd6, 1'b0, 1'b1); tick();
    apply_stimulus(1'b1, 32'h7108, 32'd7, 1'b0, 1'b1); tick();
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    check_output("midrst_buffered", idle, 1'b0);
    #2 reset = 1'b0;
    #1;
    check_output("midrst_idle", idle, 1'b1);
    check_output("midrst_valid", out_valid, 1'b0);
    #2 reset = 1'b1;
    tick();
    apply_stimulus(1'b1, 32'h7000, 32'd11, 1'b0, 1'b1); tick();
    apply_stimulus(1'b1, 32'h7004, 32'd12, 1'b0, 1'b1); tick();
    apply_stimulus(1'b1, 32'h7008, 32'd13, 1'b0, 1'b1); tick();
    apply_stimulus(1'b1, 32'h700C, 32'd14, 1'b0, 1'b1); tick();
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    check_output("midrst_new_valid", out_valid, 1'b1);
    check_output("midrst_new_addr", out_addr, {32'h700C, 32'h7008, 32'h7004, 32'h7000});
    check_output("midrst_new_value", out_value, {32'd14, 32'd13, 32'd12, 32'd11});
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
